mul_div_unit: RTL



---
 rtl/md_pkg.sv | 28 ++
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide responder.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_e;

    localparam int MD_DWIDTH_DEF = 32;
    localparam int MD_CNT_W_DEF  = $clog2(MD_DWIDTH_DEF);

    function automatic int md_cnt_w(input int dw);
        return $clog2(dw);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Bit-serial RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with sign correction on the final iteration.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic [DWIDTH-1:0] MD_In_A,
    input  logic [DWIDTH-1:0] MD_In_B,
    input  logic [2:0]        MD_OP,
    input  logic              MD_Req_Valid,
    output logic              MD_Req_Ready,
    output logic [DWIDTH-1:0] MD_Out,
    output logic              MD_Resp_Valid,
    input  logic              MD_Resp_Ready
);

    localparam int CW = md_cnt_w(DWIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWIDTH - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [DWIDTH-1:0] MIN_NEG  = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_e           state_q, state_d;
    md_op_e              op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DWIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic                neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic [DWIDTH-1:0]   out_q, out_d;

    md_op_e              op_in;
    logic                sa_in, sb_in;
    logic [DWIDTH-1:0]   a_mag, b_mag;
    logic [DWIDTH:0]     mul_sum, div_trial;
    logic [2*DWIDTH-1:0] acc_step, prod_s;
    logic [DWIDTH-1:0]   quo_step, rem_step, quo_s, rem_s;

    assign op_in         = md_op_e'(MD_OP);
    assign MD_Req_Ready  = (state_q == ST_IDLE);
    assign MD_Resp_Valid = (state_q == ST_DONE);
    assign MD_Out        = out_q;

    always_comb begin
        sa_in = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & MD_In_A[DWIDTH-1];
        sb_in = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) & MD_In_B[DWIDTH-1];
        a_mag = sa_in ? -MD_In_A : MD_In_A;
        b_mag = sb_in ? -MD_In_B : MD_In_B;

        // Multiply: multiplier sits in the low half and is consumed LSB first.
        mul_sum  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
        acc_step = {mul_sum, acc_q[DWIDTH-1:1]};

        // Divide: dividend shifts out of quo_q MSB first into the partial remainder.
        div_trial = {rem_q, quo_q[DWIDTH-1]} - {1'b0, b_q};
        if (div_trial[DWIDTH]) begin
            rem_step = {rem_q[DWIDTH-2:0], quo_q[DWIDTH-1]};
            quo_step = {quo_q[DWIDTH-2:0], 1'b0};
        end else begin
            rem_step = div_trial[DWIDTH-1:0];
            quo_step = {quo_q[DWIDTH-2:0], 1'b1};
        end

        prod_s = neg_q ? -acc_step : acc_step;
        quo_s  = neg_q ? -quo_step : quo_step;
        rem_s  = neg_rem_q ? -rem_step : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        out_d     = out_q;

        case (state_q)
            ST_IDLE: begin
                if (MD_Req_Valid) begin
                    op_d      = op_in;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_d     = sa_in ^ sb_in;
                    neg_rem_d = sa_in;
                    if (op_in[2] && (MD_In_B == '0)) begin
                        out_d   = op_in[1] ? MD_In_A : '1;
                        state_d = ST_DONE;
                    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                                 (MD_In_A == MIN_NEG) && (MD_In_B == '1)) begin
                        out_d   = op_in[1] ? '0 : MD_In_A;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_LAST;
                        acc_d   = {{DWIDTH{1'b0}}, b_mag};
                        quo_d   = a_mag;
                        rem_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (op_q[2]) begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                end else begin
                    acc_d = acc_step;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    case (op_q)
                        OP_MUL:                        out_d = prod_s[DWIDTH-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU:  out_d = prod_s[2*DWIDTH-1:DWIDTH];
                        OP_DIV, OP_DIVU:               out_d = quo_s;
                        default:                       out_d = rem_s;
                    endcase
                end
            end
            ST_DONE: begin
                if (MD_Resp_Ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            out_q     <= out_d;
        end
    end

endmodule
